// File: rtl/vc_arbiter.sv
// Weighted round-robin scheduler between two virtual-channel FIFOs.
// It stalls on destination backpressure and forwards each popped word two cycles after its pop.
module vc_arbiter #(
    parameter int BITNUMBER = 5,
    parameter int CNT_W     = 4,
    parameter int WEIGHT0   = 2,
    parameter int WEIGHT1   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 empty_vc0,
    input  logic                 empty_vc1,
    input  logic [BITNUMBER-1:0] data_vc0,
    input  logic [BITNUMBER-1:0] data_vc1,
    input  logic                 almost_full_d0,
    input  logic                 almost_full_d1,
    output logic                 pop_vc0,
    output logic                 pop_vc1,
    output logic                 valid_out,
    output logic [BITNUMBER-1:0] data_out,
    output logic                 dest_sel,
    output logic                 active_vc
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, STALL} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] W0      = CNT_W'(WEIGHT0);
    localparam logic [CNT_W-1:0] W1      = CNT_W'(WEIGHT1);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             last_reg;
    logic             pipe_valid_reg;
    logic             pipe_sel_reg;
    logic             stall;
    logic [CNT_W-1:0] cnt_inc;

    assign stall     = almost_full_d0 | almost_full_d1;
    assign pop_vc0   = (state_reg == GRANT0) & ~empty_vc0 & ~stall;
    assign pop_vc1   = (state_reg == GRANT1) & ~empty_vc1 & ~stall;
    assign active_vc = (state_reg == GRANT1) | ((state_reg == STALL) & last_reg);
    // Saturating count; >= lets a counter that grew past the weight while alone still hand over.
    assign cnt_inc   = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            last_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (stall)           state_reg <= STALL;
                    else if (!empty_vc0) state_reg <= GRANT0;
                    else if (!empty_vc1) state_reg <= GRANT1;
                end
                GRANT0: begin
                    if (stall) begin
                        state_reg <= STALL;
                        last_reg  <= 1'b0;
                    end else if (!empty_vc0) begin
                        if (cnt_inc >= W0 && !empty_vc1) begin
                            state_reg <= GRANT1;
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg <= cnt_inc;
                        end
                    end else if (!empty_vc1) begin
                        state_reg <= GRANT1;
                        cnt_reg   <= '0;
                    end else begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end
                end
                GRANT1: begin
                    if (stall) begin
                        state_reg <= STALL;
                        last_reg  <= 1'b1;
                    end else if (!empty_vc1) begin
                        if (cnt_inc >= W1 && !empty_vc0) begin
                            state_reg <= GRANT0;
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg <= cnt_inc;
                        end
                    end else if (!empty_vc0) begin
                        state_reg <= GRANT0;
                        cnt_reg   <= '0;
                    end else begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end
                end
                default: begin
                    // Return to the interrupted VC keeps its count; any other exit restarts it.
                    if (!stall) begin
                        if (!last_reg && !empty_vc0) begin
                            state_reg <= GRANT0;
                        end else if (last_reg && !empty_vc1) begin
                            state_reg <= GRANT1;
                        end else if (!last_reg && !empty_vc1) begin
                            state_reg <= GRANT1;
                            last_reg  <= 1'b1;
                            cnt_reg   <= '0;
                        end else if (last_reg && !empty_vc0) begin
                            state_reg <= GRANT0;
                            last_reg  <= 1'b0;
                            cnt_reg   <= '0;
                        end else begin
                            state_reg <= IDLE;
                            cnt_reg   <= '0;
                        end
                    end
                end
            endcase
        end
    end

    // The pop is remembered for one cycle so the word is taken when the FIFO presents it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_valid_reg <= 1'b0;
            pipe_sel_reg   <= 1'b0;
            valid_out      <= 1'b0;
            data_out       <= '0;
            dest_sel       <= 1'b0;
        end else begin
            pipe_valid_reg <= pop_vc0 | pop_vc1;
            pipe_sel_reg   <= pop_vc1;
            valid_out      <= pipe_valid_reg;
            if (pipe_valid_reg) begin
                data_out <= pipe_sel_reg ? data_vc1 : data_vc0;
                dest_sel <= pipe_sel_reg ? data_vc1[BITNUMBER-1] : data_vc0[BITNUMBER-1];
            end
        end
    end

endmodule
